// File: rtl/gsim_result_buffer.sv
// -----------------------------------------------------------------------------
// gsim_result_buffer
//
// Purpose:
//   Output stage of the Gauss-Seidel solver. Each solver burst of N_WORDS
//   result words (no back-pressure) is captured into one bank of a ping-pong
//   register pair. Completed banks are replayed, oldest first, on a
//   valid/ready stream with a last flag. If a burst starts while both banks
//   are occupied, the whole burst is dropped and a sticky overflow flag is
//   raised.
//
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high
//   in_valid   in   1       solver output strobe, high N_WORDS cycles per frame
//   in_data    in   DATA_W  solver word, valid CAPTURE_DELAY cycles after in_valid
//   m_valid    out  1       output word valid
//   m_ready    in   1       consumer ready
//   m_data     out  DATA_W  output word (0 while m_valid is low)
//   m_last     out  1       high with word N_WORDS-1 of a frame
//   ovf        out  1       sticky: a frame was dropped
//   ovf_clr    in   1       clears ovf (a same-cycle drop takes priority)
//   frame_cnt  out  8       frames fully delivered, wraps 255->0
// -----------------------------------------------------------------------------
module gsim_result_buffer #(
  parameter int N_WORDS       = 16,
  parameter int DATA_W        = 32,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [7:0]        frame_cnt
);

  localparam int              IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_e;
  typedef enum logic       {R_IDLE, R_SEND}         rd_state_e;

  // ---------------------------------------------------------------------------
  // Capture enable: in_valid realigned to the registered solver data.
  // ---------------------------------------------------------------------------
  logic w_cap_en;

  generate
    if (CAPTURE_DELAY == 0) begin : g_no_delay
      assign w_cap_en = in_valid;
    end else begin : g_delay
      logic [CAPTURE_DELAY-1:0] r_dly;
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_dly <= '0;
        else       r_dly <= (r_dly << 1) | CAPTURE_DELAY'(in_valid);
      end
      assign w_cap_en = r_dly[CAPTURE_DELAY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_e         r_wr_state, w_wr_next;
  logic [IDX_W-1:0]  r_wr_idx;
  logic              r_wr_bank;
  logic [IDX_W-1:0]  r_drop_cnt;

  rd_state_e         r_rd_state, w_rd_next;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_rd_bank;

  logic [1:0]        r_busy;      // bank claimed by the writer and not yet fully read
  logic [1:0]        r_ord;       // order FIFO of completed bank ids, [0] is oldest
  logic [1:0]        r_ord_cnt;
  logic              r_ovf;
  logic [7:0]        r_frame_cnt;

  logic [DATA_W-1:0] r_bank [2][N_WORDS];

  // Read-side decode
  logic       w_m_valid;
  logic       w_xfer;
  logic       w_rd_done;
  logic       w_pop;
  logic [1:0] w_free_mask;
  logic [1:0] w_free;

  // Write-side decode
  logic             w_wr_en;
  logic             w_wr_sel;
  logic [IDX_W-1:0] w_wr_addr;
  logic [1:0]       w_claim_mask;
  logic             w_drop_start;
  logic             w_push;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (r_ord_cnt != 2'd0) w_rd_next = R_SEND;
      R_SEND:  if (w_rd_done && (r_ord_cnt == 2'd0)) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  // NOTE: every signal driven in an always_comb gets a default at the top so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_m_valid = 1'b0;
    w_xfer    = 1'b0;
    w_rd_done = 1'b0;
    w_pop     = 1'b0;
    case (r_rd_state)
      R_IDLE: w_pop = (r_ord_cnt != 2'd0);
      R_SEND: begin
        w_m_valid = 1'b1;
        w_xfer    = m_ready;
        w_rd_done = m_ready && (r_rd_idx == LAST_IDX);
        // Chain straight into the next completed bank: no bubble.
        w_pop     = w_rd_done && (r_ord_cnt != 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_idx  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_pop) begin
      r_rd_bank <= r_ord[0];
      r_rd_idx  <= '0;
    end else if (w_xfer) begin
      r_rd_idx  <= r_rd_idx + IDX_W'(1);
    end
  end

  // A bank released by this cycle's last beat is already claimable this cycle.
  assign w_free_mask = w_rd_done ? (2'b01 << r_rd_bank) : 2'b00;
  assign w_free      = ~r_busy | w_free_mask;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE: if (w_cap_en) w_wr_next = (w_free != 2'b00) ? W_FILL : W_DROP;
      W_FILL: if (w_cap_en && (r_wr_idx == LAST_IDX)) w_wr_next = W_IDLE;
      W_DROP: if (w_cap_en && (r_drop_cnt == LAST_IDX)) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_sel     = r_wr_bank;
    w_wr_addr    = r_wr_idx;
    w_claim_mask = 2'b00;
    w_drop_start = 1'b0;
    w_push       = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_cap_en) begin
          if (w_free != 2'b00) begin
            // Bank 0 preferred when both are free.
            w_wr_en      = 1'b1;
            w_wr_sel     = ~w_free[0];
            w_wr_addr    = '0;
            w_claim_mask = w_free[0] ? 2'b01 : 2'b10;
          end else begin
            w_drop_start = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (w_cap_en) begin
          w_wr_en = 1'b1;
          w_push  = (r_wr_idx == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_idx   <= '0;
      r_wr_bank  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_claim_mask != 2'b00) begin
        r_wr_bank <= w_wr_sel;
        r_wr_idx  <= IDX_W'(1);
      end else if (w_wr_en) begin
        r_wr_idx  <= r_wr_idx + IDX_W'(1);
      end

      if (w_drop_start)
        r_drop_cnt <= IDX_W'(1);
      else if ((r_wr_state == W_DROP) && w_cap_en)
        r_drop_cnt <= r_drop_cnt + IDX_W'(1);
    end
  end

  // NOTE: the bank storage has no reset; occupancy is tracked by r_busy and
  // the order FIFO, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_bank[w_wr_sel][w_wr_addr] <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Bank occupancy, completion order, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 2'b00;
      r_ord       <= 2'b00;
      r_ord_cnt   <= 2'd0;
      r_ovf       <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      // Claim after release so a bank freed and re-claimed this cycle stays busy.
      r_busy    <= (r_busy & ~w_free_mask) | w_claim_mask;
      r_ord_cnt <= r_ord_cnt + {1'b0, w_push} - {1'b0, w_pop};

      // Only two banks exist, so a push never meets a full FIFO.
      if (w_pop)
        r_ord[0] <= ((r_ord_cnt == 2'd1) && w_push) ? r_wr_bank : r_ord[1];
      else if (w_push) begin
        if (r_ord_cnt == 2'd0) r_ord[0] <= r_wr_bank;
        else                   r_ord[1] <= r_wr_bank;
      end

      if (w_drop_start) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;

      if (w_rd_done) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign m_valid   = w_m_valid;
  assign m_data    = w_m_valid ? r_bank[r_rd_bank][r_rd_idx] : '0;
  assign m_last    = w_m_valid && (r_rd_idx == LAST_IDX);
  assign ovf       = r_ovf;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_gsim_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_gsim_result_buffer
//
// Self-checking bench for gsim_result_buffer. Inputs change 1 time unit after
// the rising edge; a single negedge process compares the DUT against a
// frame-level model (word queues and an occupancy count) and then advances
// the model by the upcoming rising edge. Directed scenarios add literal
// expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_gsim_result_buffer;

  localparam int N      = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              ovf;
  logic              ovf_clr = 1'b0;
  logic [7:0]        frame_cnt;

  gsim_result_buffer #(
    .N_WORDS      (N),
    .DATA_W       (DATA_W),
    .CAPTURE_DELAY(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] exp_q[$];   // words of completed, undelivered frames
  logic [DATA_W-1:0] cur_q[$];   // words of the frame being captured
  int                held;       // frames owning a bank (capturing or awaiting delivery)
  int                wcnt;       // word position within the frame being captured
  int                out_pos;    // word position within the frame being delivered
  bit                cur_drop;
  logic              mdl_ovf;
  logic [7:0]        mdl_fcnt;
  bit                prev_iv;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  int                n_beats = 0;
  logic [DATA_W-1:0] last_data = '0;
  logic              last_flag = 1'b0;

  always @(negedge clk) begin
    logic [DATA_W-1:0] w;
    bit drop_now;
    if (reset) begin
      exp_q.delete();
      cur_q.delete();
      held = 0; wcnt = 0; out_pos = 0; cur_drop = 0;
      mdl_ovf = 1'b0; mdl_fcnt = 8'd0;
      prev_iv = 0; prev_stall = 0;
      check("rst_m_valid",   m_valid,   1'b0);
      check("rst_m_last",    m_last,    1'b0);
      check("rst_m_data",    m_data,    '0);
      check("rst_ovf",       ovf,       1'b0);
      check("rst_frame_cnt", frame_cnt, 8'd0);
    end else begin
      check("ovf",       ovf,       mdl_ovf);
      check("frame_cnt", frame_cnt, mdl_fcnt);

      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data",  m_data,  prev_data);
        check("stall_last",  m_last,  prev_last);
      end

      // Delivery at the coming edge.
      if (m_valid && m_ready) begin
        check("beat_available", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("beat_data", m_data, w);
          check("beat_last", m_last, out_pos == N - 1);
          if (out_pos == N - 1) begin
            held--;
            mdl_fcnt = mdl_fcnt + 8'd1;
          end
          out_pos = (out_pos + 1) % N;
        end
        n_beats++;
        last_data = m_data;
        last_flag = m_last;
      end

      // Capture at the coming edge: in_valid one cycle ago, data now.
      drop_now = 0;
      if (prev_iv) begin
        if (wcnt == 0) begin
          if (held < 2) begin held++; cur_drop = 0; end
          else begin cur_drop = 1; drop_now = 1; end
        end
        if (!cur_drop) cur_q.push_back(in_data);
        if (wcnt == N - 1) begin
          if (!cur_drop) foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
          cur_q.delete();
        end
        wcnt = (wcnt + 1) % N;
      end

      if (drop_now)     mdl_ovf = 1'b1;
      else if (ovf_clr) mdl_ovf = 1'b0;

      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_iv    = in_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    ovf_clr  = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  // One frame of N words; data follows its strobe by one cycle. With rnd set,
  // words are random and the strobe has random gaps.
  task automatic send_frame(input logic [DATA_W-1:0] base, input bit rnd);
    int                sent = 0;
    bit                pv = 0;
    bit                v;
    logic [DATA_W-1:0] pd = '0;
    while (sent < N || pv) begin
      tick();
      in_data = pv ? pd : DATA_W'($urandom());
      v = (sent < N) && (!rnd || ($urandom_range(0, 3) != 0));
      in_valid = v;
      if (v) begin
        pd = rnd ? DATA_W'($urandom()) : base + DATA_W'(sent);
        sent++;
      end
      pv = v;
    end
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int c = 0;
    while (n_beats < target && c < budget) begin tick(); c++; end
    if (n_beats < target) check(name, n_beats, target);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int c = 0;
    while (!m_valid && c < budget) begin tick(); c++; end
    if (!m_valid) check(name, m_valid, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  bit done_flag;

  initial begin
    int base;
    int cyc;

    // 1: single frame, consumer always ready
    apply_reset();
    m_ready = 1'b1;
    base = n_beats;
    send_frame(32'h1000_0000, 0);
    wait_valid(10, "t1_valid_timeout");
    check("t1_first_word", m_data, 32'h1000_0000);
    wait_beats(base + 16, 100, "t1_beats_timeout");
    idle(3);
    check("t1_beats",     n_beats - base, 16);
    check("t1_last_data", last_data, 32'h1000_000F);
    check("t1_last_flag", last_flag, 1'b1);
    check("t1_frame_cnt", frame_cnt, 8'd1);
    check("t1_ovf",       ovf,       1'b0);

    // 2: 5-cycle stall on word 7
    apply_reset();
    m_ready = 1'b1;
    base = n_beats;
    send_frame(32'h1000_0000, 0);
    wait_beats(base + 7, 100, "t2_pre_timeout");
    m_ready = 1'b0;
    repeat (5) begin
      tick();
      check("t2_hold_valid", m_valid, 1'b1);
      check("t2_hold_data",  m_data,  32'h1000_0007);
    end
    m_ready = 1'b1;
    wait_beats(base + 16, 100, "t2_beats_timeout");
    idle(5);
    check("t2_beats",     n_beats - base, 16);
    check("t2_frame_cnt", frame_cnt, 8'd1);

    // 3: ping-pong, two frames buffered then drained back-to-back
    apply_reset();
    base = n_beats;
    send_frame(32'h2000_0000, 0);
    idle(3);
    send_frame(32'h2100_0000, 0);
    idle(3);
    check("t3_valid_waiting", m_valid,   1'b1);
    check("t3_head_word",     m_data,    32'h2000_0000);
    check("t3_fcnt_before",   frame_cnt, 8'd0);
    m_ready = 1'b1;
    cyc = 0;
    while (n_beats < base + 32 && cyc < 100) begin tick(); cyc++; end
    check("t3_b2b_cycles", cyc, 32);
    idle(3);
    check("t3_frame_cnt", frame_cnt, 8'd2);
    check("t3_last_data", last_data, 32'h2100_000F);

    // 4: overflow, third frame dropped, then clear
    apply_reset();
    base = n_beats;
    send_frame(32'h3000_0000, 0);
    idle(2);
    send_frame(32'h3100_0000, 0);
    idle(2);
    send_frame(32'h3200_0000, 0);
    idle(3);
    check("t4_ovf_set",   ovf,    1'b1);
    check("t4_head_word", m_data, 32'h3000_0000);
    m_ready = 1'b1;
    wait_beats(base + 32, 200, "t4_beats_timeout");
    idle(20);
    check("t4_beats",      n_beats - base, 32);
    check("t4_frame_cnt",  frame_cnt, 8'd2);
    check("t4_last_data",  last_data, 32'h3100_000F);
    check("t4_ovf_sticky", ovf, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check("t4_ovf_cleared", ovf, 1'b0);

    // 5: bank released by last beat and re-claimed in the same cycle
    apply_reset();
    base = n_beats;
    send_frame(32'h5000_0000, 0);
    idle(2);
    send_frame(32'h5100_0000, 0);
    idle(3);
    m_ready = 1'b1;
    wait_beats(base + 15, 100, "t5_pre_timeout");
    m_ready = 1'b0;
    check("t5_pending_last", m_last, 1'b1);
    check("t5_pending_data", m_data, 32'h5000_000F);
    fork
      send_frame(32'h5200_0000, 0);
      begin
        tick();
        tick();
        m_ready = 1'b1;   // accepted on the edge that captures word 0 of the new frame
        tick();
        m_ready = 1'b0;
        check("t5_fcnt_at_claim", frame_cnt, 8'd1);
      end
    join
    idle(1);
    check("t5_ovf", ovf, 1'b0);
    m_ready = 1'b1;
    wait_beats(base + 48, 200, "t5_beats_timeout");
    idle(3);
    check("t5_frame_cnt", frame_cnt, 8'd3);
    check("t5_last_data", last_data, 32'h5200_000F);
    check("t5_ovf_end",   ovf,       1'b0);

    // 6: reset at word 9 of a capture, then a clean frame
    apply_reset();
    send_frame(32'h6000_0000, 0);
    idle(3);
    check("t6_valid_before", m_valid, 1'b1);
    fork
      send_frame(32'h6100_0000, 0);
      begin
        repeat (11) tick();
        reset = 1'b1;
        #1;
        check("t6_rst_valid", m_valid,   1'b0);
        check("t6_rst_last",  m_last,    1'b0);
        check("t6_rst_data",  m_data,    '0);
        check("t6_rst_ovf",   ovf,       1'b0);
        check("t6_rst_fcnt",  frame_cnt, 8'd0);
      end
    join
    tick();
    reset = 1'b0;
    m_ready = 1'b1;
    base = n_beats;
    send_frame(32'h6200_0000, 0);
    wait_beats(base + 16, 100, "t6_beats_timeout");
    idle(5);
    check("t6_beats",     n_beats - base, 16);
    check("t6_frame_cnt", frame_cnt, 8'd1);
    check("t6_last_data", last_data, 32'h6200_000F);

    // Randomized traffic against the model
    apply_reset();
    done_flag = 0;
    fork
      begin
        for (int f = 0; f < 14; f++) begin
          idle($urandom_range(0, 12));
          send_frame('0, 1);
        end
        done_flag = 1;
      end
      begin
        while (!done_flag) begin
          tick();
          m_ready = ($urandom_range(0, 99) < 35);
          ovf_clr = ($urandom_range(0, 15) == 0);
        end
      end
    join
    m_ready = 1'b1;
    ovf_clr = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || m_valid) && cyc < 400) begin tick(); cyc++; end
    idle(3);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
